// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment history display.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NUM_W      = 3;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_st_t;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 7 first.
  localparam logic [7:0][SEG_W-1:0] SEG_LUT = {
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_dec.sv
// Combinational 3-bit value to active-low seven-segment pattern decoder.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [NUM_W-1:0] digit_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_LUT[digit_i];
  end

endmodule

// File: rtl/seg7_hist_scan.sv
// Samples the counter value, keeps a 4-deep history and scans it onto a
// multiplexed common-anode display. SEG7_WRAP_DP_EN lights dp on 7->0 wrap entries.
module seg7_hist_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_W    = 16,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_W-1:0]      num_in,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  logic [NUM_W-1:0]                  s1_q;
  logic [NUM_W-1:0]                  s2_q;
  logic [1:0]                        sv_q;
  logic [NUM_W-1:0]                  last_q;
  logic                              primed_q;
  logic [NUM_DIGITS-1:0][NUM_W-1:0]  hist_q;
  logic [NUM_DIGITS-1:0]             vld_q;
  logic                              accept_c;

  logic [SCAN_W-1:0]                 presc_q;
  logic [SCAN_W-1:0]                 presc_d;
  scan_st_t                          state_q;
  scan_st_t                          state_d;

  logic [SEG_W-1:0]                  seg_q;
  logic [SEG_W-1:0]                  seg_d;
  logic                              dp_q;
  logic                              dp_d;
  logic [NUM_DIGITS-1:0]             an_q;
  logic [NUM_DIGITS-1:0]             an_d;

  logic [NUM_W-1:0]                  sel_val_c;
  logic [SEG_W-1:0]                  dec_seg_c;

  // sv_q tracks when s2 holds a real post-reset sample, so the first accept sees num_in.
  assign accept_c = sv_q[1] && (!primed_q || (s2_q != last_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      sv_q     <= '0;
      last_q   <= '0;
      primed_q <= 1'b0;
      hist_q   <= '0;
      vld_q    <= '0;
    end else begin
      s1_q <= num_in;
      s2_q <= s1_q;
      sv_q <= {sv_q[0], 1'b1};
      if (accept_c) begin
        hist_q   <= {hist_q[NUM_DIGITS-2:0], s2_q};
        vld_q    <= {vld_q[NUM_DIGITS-2:0], 1'b1};
        last_q   <= s2_q;
        primed_q <= 1'b1;
      end
    end
  end

`ifdef SEG7_WRAP_DP_EN
  logic [NUM_DIGITS-1:0] wrap_q;
  logic                  wrap_new_c;

  assign wrap_new_c = primed_q && (last_q == NUM_W'(7)) && (s2_q == NUM_W'(0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= '0;
    end else if (accept_c) begin
      wrap_q <= {wrap_q[NUM_DIGITS-2:0], wrap_new_c};
    end
  end
`endif

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIG0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    presc_d = presc_q + SCAN_W'(1);
    state_d = state_q;
    if (presc_q == {SCAN_W{1'b1}}) begin
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        DIG3:    state_d = DIG0;
        default: state_d = DIG0;
      endcase
    end
  end

  assign sel_val_c = hist_q[state_d];

  seg7_dec u_dec (
    .digit_i (sel_val_c),
    .seg_c_o (dec_seg_c)
  );

  // Outputs follow the next scan position; history is the pre-accept copy.
  always_comb begin
    an_d  = {NUM_DIGITS{1'b1}};
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (presc_d >= SCAN_W'(BLANK_CYC)) begin
      an_d = ~(NUM_DIGITS'(1) << state_d);
    end
    if (vld_q[state_d]) begin
      seg_d = dec_seg_c;
`ifdef SEG7_WRAP_DP_EN
      dp_d  = ~wrap_q[state_d];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= {NUM_DIGITS{1'b1}};
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
